// File: rtl/regfile_bank_8.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// regfile_bank_8
//   Eight-entry register bank fed by a 3-to-8 one-hot write-select decoder.
//   A single legal (exactly one-hot) select writes wr_data into that register on
//   the rising clock edge. A zero select is idle. A multi-hot select writes
//   nothing and sets a sticky error flag that only reset clears.
//   Two independent combinational read ports.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : a legal write is forwarded to any read port addressing the
//                 target register in the same cycle
//     undefined : reads always return the stored (pre-edge) value
//
// Ports
//   clk         in   1      clock, all state updates on posedge
//   reset       in   1      asynchronous, active-high, clears all state
//   wr_sel      in   8      one-hot write select (bit i = register i)
//   wr_data     in   WIDTH  write data
//   rd_addr_a   in   3      read port A index
//   rd_addr_b   in   3      read port B index
//   rd_data_a   out  WIDTH  register[rd_addr_a]
//   rd_data_b   out  WIDTH  register[rd_addr_b]
//   onehot_err  out  1      sticky: multi-hot wr_sel seen at a clock edge
// -----------------------------------------------------------------------------
module regfile_bank_8 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr_a,
  input  logic [2:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             onehot_err
);

  localparam int unsigned NREGS = 8;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             onehot_err_q;
  logic             onehot_err_d;

  logic             sel_any;
  logic             sel_legal;
  logic             sel_multi;

  // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
  always_comb begin
    sel_any   = |wr_sel;
    sel_legal = sel_any && ((wr_sel & (wr_sel - 8'd1)) == 8'd0);
    sel_multi = sel_any && !sel_legal;
  end

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (sel_legal && wr_sel[i]) begin
        regs_d[i] = wr_data;
      end
    end
    onehot_err_d = onehot_err_q | sel_multi;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      onehot_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      onehot_err_q <= onehot_err_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    // Forward only on a legal write; a multi-hot select writes nothing, so
    // nothing may be forwarded either.
    if (sel_legal && wr_sel[rd_addr_a]) begin
      rd_data_a = wr_data;
    end
    if (sel_legal && wr_sel[rd_addr_b]) begin
      rd_data_b = wr_data;
    end
`endif
  end

  assign onehot_err = onehot_err_q;

endmodule

// File: tb/tb_regfile_bank_8.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_regfile_bank_8
//   Directed scenarios followed by randomized traffic, compared against an
//   array-based model of the eight registers and the sticky error flag.
// -----------------------------------------------------------------------------
module tb_regfile_bank_8;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   wr_sel;
  logic [W-1:0] wr_data;
  logic [2:0]   rd_addr_a;
  logic [2:0]   rd_addr_b;
  logic [W-1:0] rd_data_a;
  logic [W-1:0] rd_data_b;
  logic         onehot_err;

  regfile_bank_8 #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .onehot_err (onehot_err)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mdl [8];
  logic         mdl_err;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected read value for the current inputs.
  function automatic logic [W-1:0] exp_rd(input logic [2:0] a);
    logic [W-1:0] v;
    v = mdl[a];
`ifdef REGFILE_BYPASS_EN
    if ($countones(wr_sel) == 1 && wr_sel[a]) v = wr_data;
`endif
    return v;
  endfunction

  task automatic check_reads(input string tag);
    check_val({tag, "_a"}, rd_data_a, exp_rd(rd_addr_a));
    check_val({tag, "_b"}, rd_data_b, exp_rd(rd_addr_b));
    check_val({tag, "_err"}, {{(W-1){1'b0}}, onehot_err}, {{(W-1){1'b0}}, mdl_err});
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    mdl_err = 1'b0;
  endtask

  task automatic model_edge();
    int n;
    n = $countones(wr_sel);
    if (n == 1) begin
      for (int i = 0; i < 8; i++) if (wr_sel[i]) mdl[i] = wr_data;
    end else if (n >= 2) begin
      mdl_err = 1'b1;
    end
  endtask

  // One clock cycle: drive after the falling edge, check before and after the rising edge.
  task automatic cycle(input logic [7:0] sel, input logic [W-1:0] data,
                       input logic [2:0] a, input logic [2:0] b, input string tag);
    @(negedge clk);
    wr_sel    = sel;
    wr_data   = data;
    rd_addr_a = a;
    rd_addr_b = b;
    #1;
    check_reads({tag, "_pre"});
    @(posedge clk);
    model_edge();
    #1;
    check_reads({tag, "_post"});
  endtask

  // Asynchronous reset pulse placed mid-low-phase; reads must clear with no clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    wr_sel = 8'h00;
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    check_reads(tag);
    #1;
    reset = 1'b0;
  endtask

  logic [7:0]   rsel;
  logic [W-1:0] rdat;
  logic [W-1:0] k64;

  initial begin
    reset     = 1'b1;
    wr_sel    = 8'h00;
    wr_data   = '0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd7;
    model_clear();
    #3;
    check_reads("reset_hold");
    @(negedge clk);
    reset = 1'b0;

    // Write each register with a distinct pattern, then read all through both ports.
    for (int k = 0; k < 8; k++) begin
      k64 = 64'(k);
      cycle(8'(1 << k), 64'hA5A5_0000_0000_0000 | k64, 3'(k), 3'(7 - k), "wr_k");
    end
    for (int k = 0; k < 8; k++) begin
      k64 = 64'(k);
      cycle(8'h00, '0, 3'(k), 3'(k ^ 3), "rd_all");
      check_val("rd_all_const", rd_data_a, 64'hA5A5_0000_0000_0000 | k64);
    end

    // Asynchronous reset with non-zero contents: every address reads 0.
    pulse_reset("async_rst");
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rd_addr_a = 3'(k);
      rd_addr_b = 3'(7 - k);
      #1;
      check_reads("rst_sweep");
    end
    reset = 1'b0;

    // Preload, then idle with all-ones data.
    for (int k = 0; k < 8; k++) cycle(8'(1 << k), {32'h0BAD_0000, 32'(k)}, 3'(k), 3'(k), "preload");
    for (int c = 0; c < 4; c++) cycle(8'h00, '1, 3'(c), 3'(c + 4), "idle");

    // Multi-hot select: nothing written, error set; a later legal write still lands.
    cycle(8'h05, 64'hDEAD, 3'd0, 3'd2, "multi");
    check_val("multi_err_const", {{(W-1){1'b0}}, onehot_err}, 64'd1);
    check_val("multi_r0_const", rd_data_a, 64'h0BAD_0000_0000_0000);
    cycle(8'h08, 64'h3333, 3'd3, 3'd0, "legal_after");
    check_val("legal_r3_const", rd_data_a, 64'h3333);

    // Same-cycle read/write hazard on register 4.
    cycle(8'h10, 64'h1111, 3'd4, 3'd4, "hz_pre");
    @(negedge clk);
    wr_sel = 8'h10; wr_data = 64'h2222; rd_addr_a = 3'd4; rd_addr_b = 3'd1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_val("hazard_before", rd_data_a, 64'h2222);
`else
    check_val("hazard_before", rd_data_a, 64'h1111);
`endif
    @(posedge clk);
    model_edge();
    #1;
    check_val("hazard_after", rd_data_a, 64'h2222);

    // Both ports on the same register.
    cycle(8'h40, 64'h6666_6666_6666_6666, 3'd6, 3'd6, "same6_w");
    cycle(8'h00, '0, 3'd6, 3'd6, "same6_r");

    // Randomized traffic with occasional resets.
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset("rnd_rst");
      case ($urandom_range(0, 9))
        0, 1:    rsel = 8'h00;
        8, 9: begin
          rsel = 8'($urandom);
          if ($countones(rsel) < 2) rsel = rsel | 8'h81;
        end
        default: rsel = 8'(1 << $urandom_range(0, 7));
      endcase
      rdat = {$urandom, $urandom};
      cycle(rsel, rdat, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
